cacheline_arbiter: RTL and testbench

Two-port arbiter that shares the single physical-memory (L2/pmem) cacheline port between the instruction cache and the data cache of the pipelined RV32I core. It accepts whole-line read requests from the I-cache and read or write-back requests from the D-cache. It grants one requester at a time, holds the downstream request stable until `pmem_resp`, and routes the response back to the granted side. It sits between the two L1 caches and the memory interface at the top of the processor.

---
 rtl/cacheline_arbiter_if.sv | 35 +++
 rtl/cacheline_arbiter.sv | 103 ++++++++++
 tb/tb_cacheline_arbiter.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/cacheline_arbiter_if.sv
// Cacheline port bundle between the two L1 caches, the arbiter and pmem.
// slave = arbiter view, master = cache/memory environment view.
interface cacheline_arbiter_if #(
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32
);
  logic              i_read;
  logic [ADDR_W-1:0] i_address;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;

  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_address;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;

  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;

  modport slave (
    input  i_read, i_address, d_read, d_write, d_address, d_wdata, pmem_rdata, pmem_resp,
    output i_rdata, i_resp, d_rdata, d_resp, pmem_read, pmem_write, pmem_address, pmem_wdata
  );

  modport master (
    output i_read, i_address, d_read, d_write, d_address, d_wdata, pmem_rdata, pmem_resp,
    input  i_rdata, i_resp, d_rdata, d_resp, pmem_read, pmem_write, pmem_address, pmem_wdata
  );
endinterface

// File: rtl/cacheline_arbiter.sv
// Shares one pmem cacheline port between I-cache and D-cache; CACHELINE_ARB_RR_EN selects round-robin.
// Latency: one cycle request-to-pmem, resp passed through combinationally in the pmem_resp cycle.
// Backpressure: requesters hold level requests until their resp; the loser simply waits in IDLE.
module cacheline_arbiter #(
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32
) (
  input logic             clk,
  input logic             rst,
  cacheline_arbiter_if.slave bus
);

`ifdef CACHELINE_ARB_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;

  state_t            state, state_nxt;
  logic              last_grant;
  logic              i_pend, d_pend, pick_d;
  logic              grant_i, grant_d;
  logic              i_resp_c, d_resp_c;
  logic              pmem_read_q, pmem_write_q;
  logic [ADDR_W-1:0] pmem_address_q;
  logic [LINE_W-1:0] pmem_wdata_q;

  assign i_pend = bus.i_read;
  assign d_pend = bus.d_read | bus.d_write;

  always_comb begin
    state_nxt = state;
    grant_i   = 1'b0;
    grant_d   = 1'b0;
    i_resp_c  = 1'b0;
    d_resp_c  = 1'b0;
    // Under fixed priority D wins any tie; round-robin lets I win a tie only after a D grant.
    pick_d    = d_pend & (~RR_EN | ~i_pend | ~last_grant);
    unique case (state)
      IDLE: begin
        grant_d = pick_d;
        grant_i = i_pend & ~pick_d;
        if (grant_d)      state_nxt = SERVE_D;
        else if (grant_i) state_nxt = SERVE_I;
      end
      SERVE_I: begin
        if (bus.pmem_resp) begin
          i_resp_c  = 1'b1;
          state_nxt = IDLE;
        end
      end
      SERVE_D: begin
        if (bus.pmem_resp) begin
          d_resp_c  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      last_grant     <= 1'b0;
      pmem_read_q    <= 1'b0;
      pmem_write_q   <= 1'b0;
      pmem_address_q <= '0;
      pmem_wdata_q   <= '0;
    end else begin
      state <= state_nxt;
      if (grant_i) begin
        pmem_read_q    <= 1'b1;
        pmem_write_q   <= 1'b0;
        pmem_address_q <= bus.i_address;
        pmem_wdata_q   <= '0;
        last_grant     <= 1'b0;
      end else if (grant_d) begin
        // A simultaneous read+write from the D-cache is a write-back.
        pmem_read_q    <= ~bus.d_write;
        pmem_write_q   <= bus.d_write;
        pmem_address_q <= bus.d_address;
        pmem_wdata_q   <= bus.d_wdata;
        last_grant     <= 1'b1;
      end else if ((state != IDLE) && bus.pmem_resp) begin
        pmem_read_q    <= 1'b0;
        pmem_write_q   <= 1'b0;
      end
    end
  end

  assign bus.i_resp       = i_resp_c;
  assign bus.d_resp       = d_resp_c;
  assign bus.i_rdata      = bus.pmem_rdata;
  assign bus.d_rdata      = bus.pmem_rdata;
  assign bus.pmem_read    = pmem_read_q;
  assign bus.pmem_write   = pmem_write_q;
  assign bus.pmem_address = pmem_address_q;
  assign bus.pmem_wdata   = pmem_wdata_q;

endmodule

// File: tb/tb_cacheline_arbiter.sv
// Scoreboard bench for cacheline_arbiter: pmem responder checks downstream requests, monitor checks resps.
module tb_cacheline_arbiter;

  typedef struct {
    logic         wr;
    logic [31:0]  addr;
    logic [255:0] wdata;
    logic [255:0] rdata;
  } req_t;

  typedef struct {
    logic         is_d;
    logic [255:0] data;
  } resp_t;

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  int   rsp_lat  = 3;
  bit   rsp_auto = 1'b1;

  req_t  req_q[$];
  resp_t resp_q[$];

  cacheline_arbiter_if #(.LINE_W(256), .ADDR_W(32)) bus ();

  cacheline_arbiter #(.LINE_W(256), .ADDR_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic expect_txn(input bit is_d, input bit wr, input logic [31:0] addr,
                            input logic [255:0] wdata, input logic [255:0] rdata);
    req_t  r;
    resp_t p;
    r.wr = wr; r.addr = addr; r.wdata = wdata; r.rdata = rdata;
    p.is_d = is_d; p.data = rdata;
    req_q.push_back(r);
    resp_q.push_back(p);
  endtask

  // Called at posedge+1; holds the request until its resp, then drops it after the next edge.
  task automatic do_req(input bit is_d, input bit rd, input bit wr, input logic [31:0] addr,
                        input logic [255:0] wdata);
    bit got;
    got = 1'b0;
    if (is_d) begin
      bus.d_read = rd; bus.d_write = wr; bus.d_address = addr; bus.d_wdata = wdata;
    end else begin
      bus.i_read = 1'b1; bus.i_address = addr;
    end
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (is_d ? bus.d_resp : bus.i_resp) begin
        got = 1'b1;
        break;
      end
    end
    chk(is_d ? "d_resp_timeout" : "i_resp_timeout", got, 1);
    @(posedge clk); #1;
    if (is_d) begin
      bus.d_read = 1'b0; bus.d_write = 1'b0;
    end else begin
      bus.i_read = 1'b0;
    end
  endtask

  // Downstream memory model: checks each new request against the expected queue.
  initial begin
    req_t cur;
    forever begin
      @(posedge clk); #1;
      if (rsp_auto && (bus.pmem_read || bus.pmem_write)) begin
        if (req_q.size() == 0) begin
          chk("pmem_unexpected", {bus.pmem_read, bus.pmem_write}, 2'b00);
          cur.wr = bus.pmem_write; cur.addr = bus.pmem_address; cur.wdata = '0; cur.rdata = '0;
        end else begin
          cur = req_q.pop_front();
          chk("pmem_addr", bus.pmem_address, cur.addr);
          chk("pmem_rw", {bus.pmem_read, bus.pmem_write}, cur.wr ? 2'b01 : 2'b10);
          if (cur.wr) chk("pmem_wdata", bus.pmem_wdata, cur.wdata);
        end
        repeat (rsp_lat) begin
          @(posedge clk); #1;
          chk("pmem_addr_stable", bus.pmem_address, cur.addr);
          chk("pmem_rw_stable", {bus.pmem_read, bus.pmem_write}, cur.wr ? 2'b01 : 2'b10);
          if (cur.wr) chk("pmem_wdata_stable", bus.pmem_wdata, cur.wdata);
        end
        bus.pmem_rdata = cur.rdata;
        bus.pmem_resp  = 1'b1;
        @(posedge clk); #1;
        bus.pmem_resp  = 1'b0;
        chk("pmem_clear", {bus.pmem_read, bus.pmem_write}, 2'b00);
      end
    end
  end

  // Response monitor: every resp pulse must match the next expected response.
  always @(negedge clk) begin
    resp_t e;
    if (bus.i_resp || bus.d_resp) begin
      if (resp_q.size() == 0) begin
        chk("resp_unexpected", {bus.i_resp, bus.d_resp}, 2'b00);
      end else begin
        e = resp_q.pop_front();
        chk("resp_side", {bus.i_resp, bus.d_resp}, e.is_d ? 2'b01 : 2'b10);
        chk("resp_rdata", e.is_d ? bus.d_rdata : bus.i_rdata, e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] a5_line, wb_line, wr_rd;
    a5_line = {8{32'hA5A5_A5A5}};
    wb_line = {8{32'h1234_5678}};
    wr_rd   = {8{32'hDEAD_BEEF}};

    rst = 1'b0;
    bus.i_read = 1'b0; bus.i_address = '0;
    bus.d_read = 1'b0; bus.d_write = 1'b0; bus.d_address = '0; bus.d_wdata = '0;
    bus.pmem_rdata = '0; bus.pmem_resp = 1'b0;

    #3;
    chk("rst_pmem_rw", {bus.pmem_read, bus.pmem_write}, 2'b00);
    chk("rst_pmem_addr", bus.pmem_address, 32'h0);
    chk("rst_pmem_wdata", bus.pmem_wdata, 256'h0);
    chk("rst_resp", {bus.i_resp, bus.d_resp}, 2'b00);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // Single I-cache read, with grant latency checked directly.
    @(posedge clk); #1;
    expect_txn(1'b0, 1'b0, 32'h0000_1000, '0, a5_line);
    fork
      do_req(1'b0, 1'b1, 1'b0, 32'h0000_1000, '0);
      begin
        @(posedge clk); #1;
        chk("grant_lat_read", bus.pmem_read, 1'b1);
        chk("grant_lat_addr", bus.pmem_address, 32'h0000_1000);
      end
    join

    // D-cache write-back.
    expect_txn(1'b1, 1'b1, 32'h0000_2000, wb_line, wr_rd);
    do_req(1'b1, 1'b0, 1'b1, 32'h0000_2000, wb_line);

    // Simultaneous I and D reads, four pairs.
    for (int k = 0; k < 4; k++) begin
      logic [255:0] idat, ddat;
      idat = {8{32'h1000_0000 | 32'(k)}};
      ddat = {8{32'h2000_0000 | 32'(k)}};
`ifdef CACHELINE_ARB_RR_EN
      expect_txn(1'b0, 1'b0, 32'h0000_0100, '0, idat);
      expect_txn(1'b1, 1'b0, 32'h0000_0200, '0, ddat);
`else
      expect_txn(1'b1, 1'b0, 32'h0000_0200, '0, ddat);
      expect_txn(1'b0, 1'b0, 32'h0000_0100, '0, idat);
`endif
      fork
        do_req(1'b0, 1'b1, 1'b0, 32'h0000_0100, '0);
        do_req(1'b1, 1'b1, 1'b0, 32'h0000_0200, '0);
      join
    end

    // d_read and d_write together: one write transaction.
    expect_txn(1'b1, 1'b1, 32'h0000_0400, {8{32'hCAFE_0001}}, {8{32'h0BAD_F00D}});
    do_req(1'b1, 1'b1, 1'b1, 32'h0000_0400, {8{32'hCAFE_0001}});

    // I address changes mid-service; pmem address must not follow.
    expect_txn(1'b0, 1'b0, 32'h0000_0100, '0, {8{32'h5555_AAAA}});
    fork
      do_req(1'b0, 1'b1, 1'b0, 32'h0000_0100, '0);
      begin
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.i_address = 32'h0000_0300;
      end
    join

    // Reset while serving D: outputs clear asynchronously and a late resp is ignored.
    rsp_auto = 1'b0;
    @(posedge clk); #1;
    bus.d_read = 1'b1; bus.d_address = 32'h0000_0800;
    @(posedge clk); #1;
    chk("serve_d_read", bus.pmem_read, 1'b1);
    chk("serve_d_addr", bus.pmem_address, 32'h0000_0800);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("arst_pmem_rw", {bus.pmem_read, bus.pmem_write}, 2'b00);
    chk("arst_pmem_addr", bus.pmem_address, 32'h0);
    chk("arst_pmem_wdata", bus.pmem_wdata, 256'h0);
    bus.d_read = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    bus.pmem_rdata = {8{32'h7777_7777}};
    bus.pmem_resp  = 1'b1;
    @(negedge clk);
    chk("late_resp_d", bus.d_resp, 1'b0);
    chk("late_resp_i", bus.i_resp, 1'b0);
    @(posedge clk); #1;
    bus.pmem_resp = 1'b0;
    chk("late_resp_idle", {bus.pmem_read, bus.pmem_write}, 2'b00);
    rsp_auto = 1'b1;

    repeat (5) @(posedge clk);
    chk("resp_q_drained", 256'(resp_q.size()), 256'h0);
    chk("req_q_drained", 256'(req_q.size()), 256'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
